// File: rtl/sram_lsu.sv
`default_nettype none
// ============================================================================
// Module   : sram_lsu
// Purpose  : CPU-side load/store initiator for the SRAM controller request
//            interface. Turns byte/half/word requests into a single-cycle
//            strobe with byte enables, waits WAIT_CYCLES access cycles,
//            pulses valid to release the controller and returns extended
//            load data with a one-cycle done pulse.
// Options  : SRAM_LSU_BUSY_CHECK_EN - abort with err when the controller is
//            not busy in the first WAIT cycle (busy_i ignored otherwise).
// Revision : 1.0 - initial release
// ============================================================================
module sram_lsu #(
    parameter int WAIT_CYCLES = 2,
    parameter int CNT_W       = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        ready_o,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic        re_n_o,
    output logic        we_n_o,
    output logic [3:0]  be_n_o,
    output logic [31:0] wdata_o,
    output logic [31:0] addr_o,
    input  logic        busy_i,
    input  logic [31:0] rdata_i,
    output logic        valid_o
);

    localparam logic [2:0]       c_IDLE     = 3'd0;
    localparam logic [2:0]       c_ISSUE    = 3'd1;
    localparam logic [2:0]       c_WAIT     = 3'd2;
    localparam logic [2:0]       c_ACK      = 3'd3;
    localparam logic [2:0]       c_DONE     = 3'd4;
    localparam logic [CNT_W-1:0] c_CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

    logic [2:0]       r_state;
    logic [2:0]       w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_we;
    logic [1:0]       r_size;
    logic             r_uns;
    logic [1:0]       r_lane;
    logic             r_err;

    logic             w_misaligned;
    logic [3:0]       w_be_n;
    logic [31:0]      w_wdata;
    logic [7:0]       w_byte;
    logic [15:0]      w_half;
    logic [31:0]      w_ext;

`ifndef SRAM_LSU_BUSY_CHECK_EN
    logic w_unused_busy;
    assign w_unused_busy = busy_i;
`endif

    // Alignment check, byte-enable pattern and lane replication of store data
    always_comb begin
        w_misaligned = 1'b0;
        w_be_n       = 4'hF;
        w_wdata      = wdata_i;
        case (size_i)
            2'b00: begin
                w_be_n  = ~(4'b0001 << addr_i[1:0]);
                w_wdata = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                w_misaligned = addr_i[0];
                w_be_n       = addr_i[1] ? 4'b0011 : 4'b1100;
                w_wdata      = {2{wdata_i[15:0]}};
            end
            2'b10: begin
                w_misaligned = |addr_i[1:0];
                w_be_n       = 4'b0000;
            end
            default: w_misaligned = 1'b1;
        endcase
    end

    // Lane extraction and sign/zero extension of the controller read data
    always_comb begin
        w_byte = rdata_i[{r_lane, 3'b000} +: 8];
        w_half = r_lane[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (r_size)
            2'b00:   w_ext = r_uns ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
            2'b01:   w_ext = r_uns ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
            default: w_ext = rdata_i;
        endcase
    end

    // Next-state logic of the request sequencer
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:  if (req_i) w_next_state = w_misaligned ? c_DONE : c_ISSUE;
            c_ISSUE: w_next_state = c_WAIT;
            c_WAIT: begin
`ifdef SRAM_LSU_BUSY_CHECK_EN
                // First WAIT cycle is the one where the counter still holds its load value
                if (r_cnt == c_CNT_LOAD && !busy_i) w_next_state = c_DONE;
                else if (r_cnt == '0)               w_next_state = c_ACK;
`else
                if (r_cnt == '0) w_next_state = c_ACK;
`endif
            end
            c_ACK:   w_next_state = c_DONE;
            c_DONE:  w_next_state = c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    // State, wait counter, latched request context and registered SRAM-side outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= c_IDLE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_size  <= 2'b00;
            r_uns   <= 1'b0;
            r_lane  <= 2'b00;
            r_err   <= 1'b0;
            addr_o  <= '0;
            be_n_o  <= 4'hF;
            wdata_o <= '0;
            rdata_o <= '0;
        end else begin
            r_state <= w_next_state;
            // Any entry into DONE other than from ACK is an error completion
            r_err   <= (w_next_state == c_DONE) && (r_state != c_ACK);

            if (r_state == c_IDLE && req_i && !w_misaligned) begin
                addr_o  <= {addr_i[31:2], 2'b00};
                be_n_o  <= w_be_n;
                wdata_o <= w_wdata;
                r_we    <= we_i;
                r_size  <= size_i;
                r_uns   <= unsigned_i;
                r_lane  <= addr_i[1:0];
            end

            if (r_state == c_ISSUE) begin
                r_cnt <= c_CNT_LOAD;
            end else if (r_state == c_WAIT && r_cnt != '0) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end

            if (r_state == c_ACK && !r_we) begin
                rdata_o <= w_ext;
            end

            // Byte enables are released once the access is over (normal or aborted)
            if (w_next_state == c_DONE) begin
                be_n_o <= 4'hF;
            end
        end
    end

    assign ready_o = (r_state == c_IDLE);
    assign re_n_o  = !((r_state == c_ISSUE) && !r_we);
    assign we_n_o  = !((r_state == c_ISSUE) && r_we);
    assign valid_o = (r_state == c_ACK);
    assign done_o  = (r_state == c_DONE);
    assign err_o   = r_err;

endmodule
`default_nettype wire
